div32_iter: RTL

//  - Iterative radix-2 restoring divider for the CPU execute stage; one quotient bit per clock.
//  - Sits upstream of the 32-bit 2:1 writeback mux; q or r drives that mux's a1 leg.
//  - Control unit stalls the PC while busy=1; writeback is enabled on done=1.

---
 rtl/div32_iter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/div32_iter.sv
// div32_iter: iterative radix-2 restoring divider, one quotient bit per clock.
// Optional feature macro: DIV_SIGNED_EN (signed operands selected by the sign port).
// Results appear WIDTH+1 clocks after the accepted start. done is a one-cycle pulse
// and q/r are held until the next completed division.
module div32_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             start,
   input  logic             cancel,
   input  logic             sign,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] dvs_reg;
   logic [WIDTH-1:0] quo_reg;
   logic [WIDTH-1:0] rem_reg;
   logic [CW-1:0]    count_reg;
   logic [WIDTH-1:0] q_reg, r_reg;
   logic             done_reg;

   // Shift/trial-subtract datapath. The shifted remainder is WIDTH+1 bits and the
   // trial result carries one more bit so that its MSB is an exact borrow.
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH+1:0] trial;
   logic [WIDTH-1:0] quo_step, rem_step;
   logic             unused_trial_bit;

   // Operand magnitudes loaded on start and the final fixed-up results.
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH-1:0] fix_q, fix_r;

`ifdef DIV_SIGNED_EN
   logic             neg_a, neg_b;
   logic             neg_q_reg, neg_r_reg, dz_reg;
   logic [WIDTH-1:0] a_orig_reg;

   // Convert signed operands to magnitudes; undo the signs on the way out.
   always_comb begin
      neg_a = sign & dividend[WIDTH-1];
      neg_b = sign & divisor[WIDTH-1];
      mag_a = neg_a ? (~dividend + 1'b1) : dividend;
      mag_b = neg_b ? (~divisor + 1'b1) : divisor;
      if (dz_reg) begin
         // Divide by zero reports all ones and hands back the original dividend.
         fix_q = '1;
         fix_r = a_orig_reg;
      end else begin
         fix_q = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
         fix_r = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
      end
   end

   // Capture the sign bookkeeping together with the operands.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         dz_reg     <= 1'b0;
         a_orig_reg <= '0;
      end else if (state_reg == S_IDLE && start) begin
         neg_q_reg  <= neg_a ^ neg_b;
         neg_r_reg  <= neg_a;
         dz_reg     <= (divisor == '0);
         a_orig_reg <= dividend;
      end
   end
`else
   logic unused_sign;

   // Unsigned only: operands pass straight through and sign is ignored.
   always_comb begin
      mag_a       = dividend;
      mag_b       = divisor;
      fix_q       = quo_reg;
      fix_r       = rem_reg;
      unused_sign = sign;
   end
`endif

   // One restoring step: shift {rem,quo} left, keep the trial result if it did not borrow.
   always_comb begin
      rem_shift        = {rem_reg, quo_reg[WIDTH-1]};
      trial            = {1'b0, rem_shift} - {2'b00, dvs_reg};
      unused_trial_bit = trial[WIDTH];
      if (!trial[WIDTH+1]) begin
         rem_step = trial[WIDTH-1:0];
         quo_step = {quo_reg[WIDTH-2:0], 1'b1};
      end else begin
         rem_step = rem_shift[WIDTH-1:0];
         quo_step = {quo_reg[WIDTH-2:0], 1'b0};
      end
   end

   // State register.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic. start wins over cancel in IDLE, and cancel is ignored in DONE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (start) state_next = S_BUSY;
         S_BUSY: begin
            if (cancel)                       state_next = S_IDLE;
            else if (count_reg == CW'(1))     state_next = S_DONE;
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Datapath registers: load on start, iterate in BUSY, publish results in DONE.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         dvs_reg   <= '0;
         quo_reg   <= '0;
         rem_reg   <= '0;
         count_reg <= '0;
         q_reg     <= '0;
         r_reg     <= '0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= (state_reg == S_DONE);
         case (state_reg)
            S_IDLE: if (start) begin
               dvs_reg   <= mag_b;
               quo_reg   <= mag_a;
               rem_reg   <= '0;
               count_reg <= CW'(WIDTH);
            end
            S_BUSY: if (!cancel) begin
               quo_reg   <= quo_step;
               rem_reg   <= rem_step;
               count_reg <= count_reg - 1'b1;
            end
            S_DONE: begin
               q_reg <= fix_q;
               r_reg <= fix_r;
            end
            default: ;
         endcase
      end
   end

   assign q    = q_reg;
   assign r    = r_reg;
   assign busy = (state_reg == S_BUSY);
   assign done = done_reg;

endmodule
